// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: conditions raw board switch/button pins for the general-purpose input bus.
// Each bit goes through a 2-flop synchroniser, then a consecutive-stable-cycle debounce counter,
// then registered one-cycle rise/fall pulse generation.
//
// Ports:
//   clk_sys_i  system clock
//   rst_sys_i  synchronous active-high reset
//   pin_i      raw asynchronous board inputs
//   gp_o       debounced level per bit
//   rise_o     one-cycle pulse on an accepted 0->1 change
//   fall_o     one-cycle pulse on an accepted 1->0 change
module gpio_in_debounce #(
  parameter int unsigned Width          = 5,
  parameter int unsigned DebounceCycles = 50000,
  localparam int unsigned CntWidth      = $clog2(DebounceCycles + 1)
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] pin_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  if (DebounceCycles == 0) begin : gen_bad_debounce
    $error("gpio_in_debounce: DebounceCycles must be at least 1");
  end

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

  logic [Width-1:0]    sync1_q, sync2_q;
  logic [Width-1:0]    gp_q, gp_d;
  logic [Width-1:0]    rise_q, rise_d;
  logic [Width-1:0]    fall_q, fall_d;
  logic [CntWidth-1:0] cnt_q [Width];
  logic [CntWidth-1:0] cnt_d [Width];

  // Counter only runs while the synchronised level disagrees with the accepted level, so any
  // return to the accepted level restarts the count (consecutive-only, never cumulative).
  always_comb begin
    gp_d   = gp_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < Width; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == gp_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        cnt_d[i]  = '0;
        gp_d[i]   = sync2_q[i];
        rise_d[i] = sync2_q[i];
        fall_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      gp_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      gp_q    <= gp_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gp_o   = gp_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce: a table of {reset, pins, hold cycles, expected outputs}
// records for a DebounceCycles=4 build, plus a hand-written sequence for a DebounceCycles=1 build.
module tb_gpio_in_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] pin_a, pin_b;
  logic [4:0] gp_a, rise_a, fall_a;
  logic [4:0] gp_b, rise_b, fall_b;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpio_in_debounce #(
    .Width         (5),
    .DebounceCycles(4)
  ) dut_a (
    .clk_sys_i(clk),
    .rst_sys_i(rst),
    .pin_i    (pin_a),
    .gp_o     (gp_a),
    .rise_o   (rise_a),
    .fall_o   (fall_a)
  );

  gpio_in_debounce #(
    .Width         (5),
    .DebounceCycles(1)
  ) dut_b (
    .clk_sys_i(clk),
    .rst_sys_i(rst),
    .pin_i    (pin_b),
    .gp_o     (gp_b),
    .rise_o   (rise_b),
    .fall_o   (fall_b)
  );

  // Inputs held for n edges; outputs checked after every one of those edges.
  typedef struct {
    logic       rst;
    logic [4:0] pin;
    int         n;
    logic [4:0] gp;
    logic [4:0] rise;
    logic [4:0] fall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [4:0] p, int n, logic [4:0] g, logic [4:0] rs,
                              logic [4:0] f);
    vec_t v;
    v.rst  = r;
    v.pin  = p;
    v.n    = n;
    v.gp   = g;
    v.rise = rs;
    v.fall = f;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [4:0] g, logic [4:0] rs, logic [4:0] f,
                       logic [4:0] eg, logic [4:0] ers, logic [4:0] ef);
    n_vec++;
    if ({g, rs, f} !== {eg, ers, ef} || (rs & f) != 5'b0) begin
      n_fail++;
      $display("FAIL %s: gp/rise/fall got %b/%b/%b expected %b/%b/%b", name, g, rs, f, eg, ers,
               ef);
    end
  endtask

  function automatic logic [4:0] hist(logic [4:0] seq[16], int idx);
    return (idx < 0) ? 5'b0 : seq[idx];
  endfunction

  initial begin
    logic [4:0] pb[16];
    logic [4:0] cur, prev;

    rst   = 1'b1;
    pin_a = 5'b0;
    pin_b = 5'b0;

    //   rst   pin       n  gp        rise      fall
    // Reset, then idle.
    add(1'b1, 5'b00000, 2, 5'b00000, 5'b00000, 5'b00000);
    add(1'b0, 5'b00000, 10, 5'b00000, 5'b00000, 5'b00000);
    // Bit 0 clean step: accepted on the 6th edge.
    add(1'b0, 5'b00001, 5, 5'b00000, 5'b00000, 5'b00000);
    add(1'b0, 5'b00001, 1, 5'b00001, 5'b00001, 5'b00000);
    add(1'b0, 5'b00001, 3, 5'b00001, 5'b00000, 5'b00000);
    // Bit 1 high for 3 cycles: rejected.
    add(1'b0, 5'b00011, 3, 5'b00001, 5'b00000, 5'b00000);
    add(1'b0, 5'b00001, 6, 5'b00001, 5'b00000, 5'b00000);
    // Bit 1 high for 4 cycles: accepted, then falls 4 cycles after s drops.
    add(1'b0, 5'b00011, 4, 5'b00001, 5'b00000, 5'b00000);
    add(1'b0, 5'b00001, 1, 5'b00001, 5'b00000, 5'b00000);
    add(1'b0, 5'b00001, 1, 5'b00011, 5'b00010, 5'b00000);
    add(1'b0, 5'b00001, 3, 5'b00011, 5'b00000, 5'b00000);
    add(1'b0, 5'b00001, 1, 5'b00001, 5'b00000, 5'b00010);
    add(1'b0, 5'b00001, 2, 5'b00001, 5'b00000, 5'b00000);
    // Bit 2 bounce 1,0,1,1,0,1,1,1,1...: rises on the 11th edge.
    add(1'b0, 5'b00101, 1, 5'b00001, 5'b00000, 5'b00000);
    add(1'b0, 5'b00001, 1, 5'b00001, 5'b00000, 5'b00000);
    add(1'b0, 5'b00101, 2, 5'b00001, 5'b00000, 5'b00000);
    add(1'b0, 5'b00001, 1, 5'b00001, 5'b00000, 5'b00000);
    add(1'b0, 5'b00101, 5, 5'b00001, 5'b00000, 5'b00000);
    add(1'b0, 5'b00101, 1, 5'b00101, 5'b00100, 5'b00000);
    add(1'b0, 5'b00101, 2, 5'b00101, 5'b00000, 5'b00000);
    // Drop bits 0 and 2 together.
    add(1'b0, 5'b00000, 5, 5'b00101, 5'b00000, 5'b00000);
    add(1'b0, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00101);
    add(1'b0, 5'b00000, 2, 5'b00000, 5'b00000, 5'b00000);
    // All bits rise together.
    add(1'b0, 5'b11111, 5, 5'b00000, 5'b00000, 5'b00000);
    add(1'b0, 5'b11111, 1, 5'b11111, 5'b11111, 5'b00000);
    add(1'b0, 5'b11111, 2, 5'b11111, 5'b00000, 5'b00000);
    // All bits fall together.
    add(1'b0, 5'b00000, 5, 5'b11111, 5'b00000, 5'b00000);
    add(1'b0, 5'b00000, 1, 5'b00000, 5'b00000, 5'b11111);
    add(1'b0, 5'b00000, 2, 5'b00000, 5'b00000, 5'b00000);
    // Bit 3: reset when its count is 2, pin held; full latency again after deassertion.
    add(1'b0, 5'b01000, 4, 5'b00000, 5'b00000, 5'b00000);
    add(1'b1, 5'b01000, 1, 5'b00000, 5'b00000, 5'b00000);
    add(1'b0, 5'b01000, 5, 5'b00000, 5'b00000, 5'b00000);
    add(1'b0, 5'b01000, 1, 5'b01000, 5'b01000, 5'b00000);
    add(1'b0, 5'b01000, 2, 5'b01000, 5'b00000, 5'b00000);

    foreach (vecs[v]) begin
      for (int j = 0; j < vecs[v].n; j++) begin
        rst   = vecs[v].rst;
        pin_a = vecs[v].pin;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("deb4_v%0d_c%0d", v, j), gp_a, rise_a, fall_a, vecs[v].gp, vecs[v].rise,
              vecs[v].fall);
      end
    end

    // DebounceCycles=1: gp_b after edge n equals the pin driven before edge n-2.
    rst = 1'b0;
    pb  = '{5'b10101, 5'b10101, 5'b10101, 5'b01010, 5'b00000, 5'b11111, 5'b11111, 5'b00100,
            5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
    for (int n = 0; n < 16; n++) begin
      pin_b = pb[n];
      @(posedge clk);
      @(negedge clk);
      cur  = hist(pb, n - 2);
      prev = hist(pb, n - 3);
      check($sformatf("deb1_c%0d", n), gp_b, rise_b, fall_b, cur, cur & ~prev, ~cur & prev);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
